spi_apb_master: RTL

Second-generation SPI-to-APB bridge. The whole block runs in the pclk domain and oversamples the SPI pins (mode 0) through synchronisers. Each SPI frame decodes into one full APB3 transfer (SETUP/ACCESS, wait states, pslverr, timeout) to one of BANK_NUM peripherals. Read data and a sticky status word are returned on MISO in the following frame.

---
 rtl/spi_apb_pkg.sv | 26 ++
 rtl/spi_slave_shifter.sv | 132 +++++++++++++
 rtl/spi_apb_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_apb_pkg.sv
// rtl/spi_apb_pkg.sv - shared types, status bit indices and frame geometry for the SPI-to-APB bridge
// Contents: apb_state_e (APB FSM encoding), STAT_* status bit positions,
//           cmd_width()/frame_len() constant functions for the SPI frame layout.
package spi_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_SLVERR    = 2;
  localparam int STAT_TIMEOUT   = 1;
  localparam int STAT_FRAME_ERR = 0;

  // Command field: {rw, bank, addr}
  function automatic int cmd_width(input int bank_num, input int addr_width);
    return 1 + $clog2(bank_num) + addr_width;
  endfunction

  function automatic int frame_len(input int bank_num, input int addr_width, input int data_width);
    return cmd_width(bank_num, addr_width) + data_width;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - oversampling SPI mode-0 slave front end (sync, edge detect, shift registers)
// Ports: pclk/reset        - system clock, synchronous active-high reset
//        sclk/ss/mosi/miso - SPI pins (ss active-low)
//        status/rdata      - word returned on MISO, loaded at ss fall
//        frame_start       - ss fall pulse (flags are read-to-clear on it)
//        cmd_done/cmd      - pulse once CMD_WIDTH bits arrived, with captured command
//        frame_end/frame_len_ok/data - pulse after ss rise on a frame carrying a command
module spi_slave_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 5,
  parameter int FRAME      = 13
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  input  logic [3:0]            status,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  miso,
  output logic                  frame_start,
  output logic                  cmd_done,
  output logic                  frame_end,
  output logic                  frame_len_ok,
  output logic [CMD_WIDTH-1:0]  cmd,
  output logic [DATA_WIDTH-1:0] data
);

  // Saturating counter wide enough to tell an over-long frame from an exact one.
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Sync vectors are {sclk, ss, mosi}; ss resets high so no phantom frame is seen.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME-1:0]      sin_q, sin_d, sout_q, sout_d, sout_load;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cmd_done_q, cmd_done_d, cmd_valid_q, cmd_valid_d;
  logic                  frame_end_q, frame_end_d, len_ok_q, len_ok_d;
  logic                  sclk_rise, sclk_fall, ss_fall, ss_rise, ss_low, mosi_s;

  assign sclk_rise = sync2_q[2] & ~prev_q[2];
  assign sclk_fall = ~sync2_q[2] & prev_q[2];
  assign ss_fall   = ~sync2_q[1] & prev_q[1];
  assign ss_rise   = sync2_q[1] & ~prev_q[1];
  assign ss_low    = ~sync2_q[1];
  assign mosi_s    = sync2_q[0];

  always_comb begin
    sync1_d     = {sclk, ss, mosi};
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    cnt_d       = cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    cmd_done_d  = 1'b0;
    cmd_valid_d = cmd_valid_q;
    frame_end_d = 1'b0;
    len_ok_d    = len_ok_q;

    sout_load                  = '0;
    sout_load[FRAME-1 -: 4]    = status;
    sout_load[DATA_WIDTH-1:0]  = rdata;

    if (ss_fall) begin
      cnt_d       = '0;
      cmd_valid_d = 1'b0;
      sout_d      = sout_load;
    end else if (ss_low) begin
      if (sclk_rise) begin
        sin_d = {sin_q[FRAME-2:0], mosi_s};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CMD_WIDTH - 1)) begin
          cmd_d       = sin_d[CMD_WIDTH-1:0];
          cmd_done_d  = 1'b1;
          cmd_valid_d = 1'b1;
        end
      end
      if (sclk_fall) sout_d = {sout_q[FRAME-2:0], 1'b0};
    end

    // Frames too short to carry a command are ignored entirely.
    if (ss_rise) begin
      frame_end_d = cmd_valid_q;
      len_ok_d    = (cnt_q == CNT_W'(FRAME));
      data_d      = sin_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      prev_q      <= SYNC_RST;
      cnt_q       <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_done_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      len_ok_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_done_q  <= cmd_done_d;
      cmd_valid_q <= cmd_valid_d;
      frame_end_q <= frame_end_d;
      len_ok_q    <= len_ok_d;
    end
  end

  assign miso         = ss_low & sout_q[FRAME-1];
  assign frame_start  = ss_fall;
  assign cmd_done     = cmd_done_q;
  assign frame_end    = frame_end_q;
  assign frame_len_ok = len_ok_q;
  assign cmd          = cmd_q;
  assign data         = data_q;

endmodule

// File: rtl/spi_apb_master.sv
// rtl/spi_apb_master.sv - SPI-to-APB3 bridge: one SPI frame becomes one APB transfer
// Ports: pclk/reset         - system/APB clock, synchronous active-high reset
//        sclk/ss/mosi/miso  - SPI mode-0 slave pins (ss active-low)
//        b_paddr/b_psel/b_penable/b_pwrite/b_pwdata - APB3 request side
//        b_prdata/b_pready/b_pslverr                - APB3 response side
module spi_apb_master
  import spi_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int BANK_NUM       = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic [ADDR_WIDTH-1:0] b_paddr,
  output logic [BANK_NUM-1:0]   b_psel,
  output logic                  b_penable,
  output logic                  b_pwrite,
  output logic [DATA_WIDTH-1:0] b_pwdata,
  input  logic [DATA_WIDTH-1:0] b_prdata,
  input  logic                  b_pready,
  input  logic                  b_pslverr
);

  localparam int BANK_W    = $clog2(BANK_NUM);
  localparam int CMD_WIDTH = cmd_width(BANK_NUM, ADDR_WIDTH);
  localparam int FRAME     = frame_len(BANK_NUM, ADDR_WIDTH, DATA_WIDTH);
  localparam int WAIT_W    = $clog2(TIMEOUT_CYCLES);

  logic [CMD_WIDTH-1:0]  cmd;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_start, cmd_done, frame_end, frame_len_ok;

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BANK_NUM-1:0]   psel_q, psel_d;
  logic                  penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [3:0]            status_q, status_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  logic                  cmd_rw, bank_bad, launch;
  logic [BANK_W-1:0]     cmd_bank;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  spi_slave_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (CMD_WIDTH),
    .FRAME      (FRAME)
  ) u_shifter (
    .pclk         (pclk),
    .reset        (reset),
    .sclk         (sclk),
    .ss           (ss),
    .mosi         (mosi),
    .status       (status_q),
    .rdata        (rdata_q),
    .miso         (miso),
    .frame_start  (frame_start),
    .cmd_done     (cmd_done),
    .frame_end    (frame_end),
    .frame_len_ok (frame_len_ok),
    .cmd          (cmd),
    .data         (wr_data)
  );

  assign cmd_rw   = cmd[CMD_WIDTH-1];
  assign cmd_bank = cmd[CMD_WIDTH-2 -: BANK_W];
  assign cmd_addr = cmd[ADDR_WIDTH-1:0];
  assign bank_bad = (int'(cmd_bank) >= BANK_NUM);
  // Reads go out as soon as the command is in; writes wait for a complete frame.
  assign launch   = (cmd_done && !cmd_rw) || (frame_end && cmd_rw && frame_len_ok);

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    // Read-to-clear happens first so an event in the same cycle survives.
    status_d  = frame_start ? 4'b0000 : status_q;

    if (frame_end && cmd_rw && !frame_len_ok) status_d[STAT_FRAME_ERR] = 1'b1;
    if (launch && state_q != ST_IDLE) status_d[STAT_OVERRUN] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          if (bank_bad) begin
            status_d[STAT_SLVERR] = 1'b1;
            if (!cmd_rw) rdata_d = '1;
          end else begin
            state_d  = ST_SETUP;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_rw;
            pwdata_d = wr_data;
            psel_d   = BANK_NUM'(1) << cmd_bank;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ST_ACCESS: begin
        if (b_pready) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          if (!pwrite_q) rdata_d = b_prdata;
          if (b_pslverr) status_d[STAT_SLVERR] = 1'b1;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          status_d[STAT_TIMEOUT] = 1'b1;
          if (!pwrite_q) rdata_d = '1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      wait_q    <= wait_d;
    end
  end

  assign b_paddr   = paddr_q;
  assign b_psel    = psel_q;
  assign b_penable = penable_q;
  assign b_pwrite  = pwrite_q;
  assign b_pwdata  = pwdata_q;

endmodule
